// File: rtl/serial_frame_rx_if.sv
// Bundle of the serial receive stream and the frame delivery handshake.
// The master side drives the bit stream and the consumer handshake; the slave side is the receiver.
interface serial_frame_rx_if #(
    parameter int N = 4
);
    logic         sin;
    logic         bit_en;
    logic         ready;
    logic         clr_ovr;
    logic [N-1:0] dout;
    logic         valid;
    logic         perr;
    logic         ferr;
    logic         overrun;
    logic         busy;

    modport master (
        output sin,
        output bit_en,
        output ready,
        output clr_ovr,
        input  dout,
        input  valid,
        input  perr,
        input  ferr,
        input  overrun,
        input  busy
    );

    modport slave (
        input  sin,
        input  bit_en,
        input  ready,
        input  clr_ovr,
        output dout,
        output valid,
        output perr,
        output ferr,
        output overrun,
        output busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, N LSB-first data bits, optional even parity, stop bit.
// Latency: frame visible on dout/valid at the edge that samples the stop bit.
// Backpressure: none on the stream; an undelivered frame blocks new ones, which are dropped and flag overrun.
module serial_frame_rx #(
    parameter int N         = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    serial_frame_rx_if.slave rx
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t         state_q,  state_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [N-1:0]   shreg_q,  shreg_d;
    logic           mism_q,   mism_d;
    logic [N-1:0]   dout_q,   dout_d;
    logic           valid_q,  valid_d;
    logic           perr_q,   perr_d;
    logic           ferr_q,   ferr_d;
    logic           ovr_q,    ovr_d;

    logic           accept;
    logic           last_bit;

    assign accept   = valid_q & rx.ready;
    assign last_bit = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        mism_d  = mism_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = 1'b0;
        ovr_d   = rx.clr_ovr ? 1'b0 : ovr_q;

        if (accept) begin
            valid_d = 1'b0;
        end

        if (rx.bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx.sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        shreg_d = '0;
                        mism_d  = 1'b0;
                    end
                end
                DATA: begin
                    shreg_d[cnt_q] = rx.sin;
                    cnt_d          = cnt_q + CW'(1);
                    if (last_bit) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    mism_d  = rx.sin ^ (^shreg_q);
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (rx.sin) begin
                        // A slot is free if empty or being consumed at this very edge.
                        if (!valid_q || accept) begin
                            dout_d  = shreg_q;
                            perr_d  = PARITY_EN ? mism_q : 1'b0;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            mism_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            mism_q  <= mism_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx.dout    = dout_q;
    assign rx.valid   = valid_q;
    assign rx.perr    = perr_q;
    assign rx.ferr    = ferr_q;
    assign rx.overrun = ovr_q;
    assign rx.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with N=4 and even parity enabled.
module tb_serial_frame_rx;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    serial_frame_rx_if #(.N(4)) bus ();

    serial_frame_rx #(.N(4), .PARITY_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, return just after the rising edge.
    task automatic send_bit(input logic b, input logic en, input logic rdy, input logic clr);
        @(negedge clk);
        bus.sin     = b;
        bus.bit_en  = en;
        bus.ready   = rdy;
        bus.clr_ovr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic par, input logic stp,
                              input logic rdy_stop, input logic clr_stop);
        send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i], 1'b1, 1'b0, 1'b0);
        send_bit(par, 1'b1, 1'b0, 1'b0);
        send_bit(stp, 1'b1, rdy_stop, clr_stop);
    endtask

    task automatic test_reset();
        bus.sin = 1'b1; bus.bit_en = 1'b0; bus.ready = 1'b0; bus.clr_ovr = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.dout !== 4'b0000) begin bad++; $display("FAIL reset_dout got=%b want=0000", bus.dout); end
        total++; if ({bus.valid, bus.perr, bus.ferr, bus.overrun, bus.busy} !== 5'b00000) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {bus.valid, bus.perr, bus.ferr, bus.overrun, bus.busy});
        end
        @(negedge clk);
        reset = 1'b0;
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_good_frame();
        send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL good_busy got=%b want=1", bus.busy); end
        send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL good_prestop_valid got=%b want=0", bus.valid); end
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (bus.dout !== 4'b1010) begin bad++; $display("FAIL good_dout got=%b want=1010", bus.dout); end
        total++; if ({bus.valid, bus.perr, bus.ferr, bus.busy} !== 4'b1000) begin
            bad++; $display("FAIL good_flags got=%b want=1000", {bus.valid, bus.perr, bus.ferr, bus.busy});
        end
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL good_hold_valid got=%b want=1", bus.valid); end
        send_bit(1'b1, 1'b1, 1'b1, 1'b0);
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL good_accept_valid got=%b want=0", bus.valid); end
        send_bit(1'b1, 1'b1, 1'b1, 1'b0);
        total++; if ({bus.valid, bus.dout} !== 5'b0_1010) begin
            bad++; $display("FAIL good_ready_idle got=%b want=01010", {bus.valid, bus.dout});
        end
    endtask

    task automatic test_parity_err();
        send_frame(4'b0111, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.dout !== 4'b0111) begin bad++; $display("FAIL par_dout got=%b want=0111", bus.dout); end
        total++; if ({bus.valid, bus.perr} !== 2'b11) begin bad++; $display("FAIL par_flags got=%b want=11", {bus.valid, bus.perr}); end
        send_bit(1'b1, 1'b1, 1'b1, 1'b0);
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL par_drain got=%b want=0", bus.valid); end
    endtask

    task automatic test_framing();
        send_frame(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if ({bus.ferr, bus.valid, bus.busy} !== 3'b100) begin
            bad++; $display("FAIL frm_flags got=%b want=100", {bus.ferr, bus.valid, bus.busy});
        end
        total++; if ({bus.dout, bus.perr} !== 5'b0111_1) begin
            bad++; $display("FAIL frm_keep got=%b want=01111", {bus.dout, bus.perr});
        end
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if ({bus.ferr, bus.busy} !== 2'b00) begin bad++; $display("FAIL frm_pulse got=%b want=00", {bus.ferr, bus.busy}); end
    endtask

    task automatic test_overrun();
        send_frame(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.dout !== 4'b1010) begin bad++; $display("FAIL ovr_dout got=%b want=1010", bus.dout); end
        total++; if ({bus.valid, bus.overrun, bus.perr} !== 3'b110) begin
            bad++; $display("FAIL ovr_flags got=%b want=110", {bus.valid, bus.overrun, bus.perr});
        end
        send_bit(1'b1, 1'b1, 1'b0, 1'b1);
        total++; if ({bus.valid, bus.overrun} !== 2'b10) begin
            bad++; $display("FAIL ovr_clear got=%b want=10", {bus.valid, bus.overrun});
        end
        send_frame(4'b0101, 1'b0, 1'b1, 1'b1, 1'b0);
        total++; if ({bus.dout, bus.valid, bus.overrun} !== 6'b0101_10) begin
            bad++; $display("FAIL ovr_coincide got=%b want=010110", {bus.dout, bus.valid, bus.overrun});
        end
        send_frame(4'b1010, 1'b0, 1'b1, 1'b0, 1'b1);
        total++; if ({bus.dout, bus.overrun} !== 5'b0101_1) begin
            bad++; $display("FAIL ovr_set_wins got=%b want=01011", {bus.dout, bus.overrun});
        end
        send_bit(1'b1, 1'b1, 1'b1, 1'b1);
        total++; if ({bus.valid, bus.overrun} !== 2'b00) begin
            bad++; $display("FAIL ovr_drain got=%b want=00", {bus.valid, bus.overrun});
        end
    endtask

    task automatic test_gapped();
        logic [6:0] seq;
        logic       r;
        seq = 7'b1010100;
        for (int i = 0; i < 7; i++) begin
            r = 1'($urandom_range(1, 0));
            send_bit(r, 1'b0, 1'b0, 1'b0);
            if (i == 1) begin
                total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL gap_busy got=%b want=1", bus.busy); end
            end
            send_bit(seq[i], 1'b1, 1'b0, 1'b0);
        end
        total++; if ({bus.dout, bus.valid, bus.perr, bus.ferr} !== 7'b1010_100) begin
            bad++; $display("FAIL gap_result got=%b want=1010100", {bus.dout, bus.valid, bus.perr, bus.ferr});
        end
    endtask

    task automatic test_async_reset();
        send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.dout !== 4'b0000) begin bad++; $display("FAIL arst_dout got=%b want=0000", bus.dout); end
        total++; if ({bus.valid, bus.perr, bus.ferr, bus.overrun, bus.busy} !== 5'b00000) begin
            bad++; $display("FAIL arst_flags got=%b want=00000", {bus.valid, bus.perr, bus.ferr, bus.overrun, bus.busy});
        end
        @(negedge clk);
        reset = 1'b0;
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL arst_idle got=%b want=0", bus.busy); end
        send_frame(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if ({bus.dout, bus.valid, bus.perr} !== 6'b1010_10) begin
            bad++; $display("FAIL arst_frame got=%b want=101010", {bus.dout, bus.valid, bus.perr});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_good_frame();
        test_parity_err();
        test_framing();
        test_overrun();
        test_gapped();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the data bits per frame (N >= 2).
REQ-002 The block SHALL have parameter PARITY_EN, default 1: 1 = even-parity bit present after data; 0 = no parity bit.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous, active-high.
REQ-005 Port sin, input, 1: serial data bit, normally driven from the upstream universal shift register's sout_right (LSB-first stream).
REQ-006 Port bit_en, input, 1: qualifies sin; sin is sampled only at edges where bit_en=1.
REQ-007 Port ready, input, 1: consumer accepts dout when high together with valid.
REQ-008 Port clr_ovr, input, 1: synchronous clear of overrun.
REQ-009 Port dout, output, N: last delivered frame data, bit 0 = first data bit received.
REQ-010 Port valid, output, 1: dout/perr hold an undelivered frame.
REQ-011 Port perr, output, 1: parity error flag qualified by valid.
REQ-012 Port ferr, output, 1: one-cycle pulse on stop-bit error.
REQ-013 Port overrun, output, 1: sticky flag, frame lost because the previous frame was not taken.
REQ-014 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY, STOP; all transitions occur only on edges with bit_en=1, and the FSM SHALL hold state when bit_en=0.
REQ-016 IDLE: sin=0 -> DATA with bit counter=0; sin=1 -> stay in IDLE.
REQ-017 DATA: shift sin into the working register at position counter (LSB first) and increment the counter; after the N-th bit go to PARITY if PARITY_EN=1, else STOP.
REQ-018 PARITY: record mismatch = sin XOR (XOR-reduction of the N data bits); then go to STOP.
REQ-019 STOP with sin=1, good frame: dout <= working data, perr <= mismatch (0 if PARITY_EN=0), valid <= 1; all updates take effect at the same edge that samples the stop bit; then go to IDLE.
REQ-020 STOP with sin=0, framing error: the frame is discarded; ferr=1 for exactly one clock; dout, valid and perr are unchanged; then go to IDLE.
REQ-021 Handshake: at an edge with valid=1 and ready=1, valid SHALL clear, unless REQ-022 applies.
REQ-022 When a good stop bit and a (valid=1, ready=1) acceptance coincide, the new frame SHALL load and valid SHALL stay 1, with no overrun.
REQ-023 When a good stop bit arrives while valid=1 and ready=0, the new frame SHALL be dropped, dout/perr SHALL be kept, and overrun SHALL set.
REQ-024 overrun SHALL stay set until clr_ovr=1 at an edge; if a set condition and clr_ovr coincide, the set wins.
REQ-025 ready SHALL have no effect when valid=0.
REQ-026 busy SHALL be combinational from the FSM state (state != IDLE).
REQ-027 Reception SHALL be independent of the consumer: the FSM never stalls on ready.

Reset
REQ-028 While reset=1, independent of clk: FSM=IDLE, counter=0, working register=0, dout=0, valid=0, perr=0, ferr=0, overrun=0, busy=0.
REQ-029 Reset mid-frame SHALL abandon the partial frame; after release, the next sin=0 with bit_en=1 starts a fresh frame.

Verification (N=4, PARITY_EN=1, bit_en=1 every cycle unless stated)
REQ-030 Good frame: sin 0,0,1,0,1,0,1 with ready=0 -> dout=4'b1010, valid=1, perr=0 from the stop edge on; valid holds until ready=1, then clears one edge later.
REQ-031 Parity error: sin 0,1,1,1,0,0,1 -> dout=4'b0111, perr=1, valid=1.
REQ-032 Framing error: sin 0,1,1,0,0,0,0 -> ferr high for one cycle, valid stays 0, FSM back in IDLE.
REQ-033 Overrun: deliver 4'b1010 with ready=0, then a second frame with data 4'b0101 -> dout stays 4'b1010 and overrun=1; clr_ovr=1 -> overrun=0. Repeat with ready=1 on the second frame's stop edge -> dout=4'b0101, valid=1, overrun=0.
REQ-034 Gapped bit_en: the REQ-030 frame with bit_en=0 on every other cycle (sin toggled randomly during gaps) -> identical result.
REQ-035 Asynchronous reset: assert reset between clk edges after the 2nd data bit -> all outputs 0 immediately; after release, a full REQ-030 frame decodes correctly.
